// File: rtl/sender_drive_arbiter.sv
// Round-robin arbiter sharing one two-phase sender stage among N requesters.
// Each grant toggles o_drive once; completion follows the synchronized i_free toggle.
module sender_drive_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TW          = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic [N-1:0] o_done,
  output logic         o_drive,
  input  logic         i_free,
  output logic         o_busy,
  output logic         o_timeout
);

  // state | meaning
  // IDLE  | no transaction; arbitrate when a request is pending and the sender is acked
  // WAIT  | o_drive toggled for winner; waiting for matching i_free phase or timeout
  // DONE  | ack received; o_done pulses on winner, grant released next edge
  // STALL | timed out; grant dropped, waiting for the late ack before re-arbitrating

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] CNT_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, STALL} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] free_sync;
  logic                   free_s;
  logic                   acked;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          win;
  logic [IW-1:0]          win_nxt;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          idx;
  logic                   pick_vld;
  logic [TW-1:0]          cnt;

  assign free_s  = free_sync[SYNC_STAGES-1];
  assign acked   = (free_s == o_drive);
  assign win_nxt = (int'(win) == N - 1) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) free_sync <= '0;
    else     free_sync <= {free_sync[SYNC_STAGES-2:0], i_free};
  end

  // Scan from the highest offset down so the first set bit at/after ptr wins last.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (i_req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o_gnt     <= '0;
      o_done    <= '0;
      o_drive   <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
    end else begin
      o_done    <= '0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && acked) begin
            o_gnt   <= N'(1) << pick;
            o_drive <= ~o_drive;
            win     <= pick;
            cnt     <= '0;
            o_busy  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // An ack seen on the timeout cycle takes priority.
          if (acked) begin
            o_done <= o_gnt;
            state  <= DONE;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            o_timeout <= 1'b1;
            o_gnt     <= '0;
            state     <= STALL;
          end
        end
        DONE: begin
          o_gnt  <= '0;
          ptr    <= win_nxt;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        STALL: begin
          if (acked) begin
            ptr    <= win_nxt;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sender_drive_arbiter.sv
// Directed plus randomized bench for sender_drive_arbiter with a scoreboard of expected grants.
// The bench plays the sender: it toggles i_free a chosen number of cycles after each o_drive toggle.
module tb_sender_drive_arbiter;
  localparam int N  = 4;
  localparam int SS = 2;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_req;
  logic [N-1:0] o_gnt;
  logic [N-1:0] o_done;
  logic         o_drive;
  logic         i_free;
  logic         o_busy;
  logic         o_timeout;

  int           n_vec = 0;
  int           n_err = 0;
  int           m_ptr = 0;
  logic [N-1:0] exp_q[$];
  int           tog_total = 0;
  int           fin_total = 0;
  logic         prev_drive = 1'b0;

  always #5 clk = ~clk;

  sender_drive_arbiter #(.N(N), .SYNC_STAGES(SS), .TW(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .o_done(o_done),
    .o_drive(o_drive), .i_free(i_free), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  // Independent tally of drive toggles and finished transactions.
  always @(posedge clk) begin
    prev_drive <= o_drive;
    if (!rst && o_drive !== prev_drive) tog_total <= tog_total + 1;
    if (o_done != '0 || o_timeout) fin_total <= fin_total + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int predict(input logic [N-1:0] req, input int p);
    for (int i = 0; i < N; i++)
      if (req[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  // One transaction: expect a grant, ack after ack_dly cycles, then done or timeout.
  task automatic txn(input int ack_dly, input bit drop, input string tag);
    logic         d0;
    int           w;
    logic [N-1:0] eg;
    logic [N-1:0] done_v;
    int           c, done_c, to_c;
    bit           got, saw_done, saw_to;
    w = predict(i_req, m_ptr);
    exp_q.push_back(N'(1) << w);
    d0  = o_drive;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (o_drive !== d0) got = 1'b1;
    end
    chk({tag, ":grant_seen"}, 32'(got), 32'(1));
    eg = exp_q.pop_front();
    if (!got) return;
    chk({tag, ":gnt"}, 32'(o_gnt), 32'(eg));
    chk({tag, ":busy"}, 32'(o_busy), 32'(1));
    if (drop) i_req = '0;
    c = 0; done_c = 0; to_c = 0; saw_done = 1'b0; saw_to = 1'b0; done_v = '0;
    if (ack_dly == 0) i_free = ~i_free;
    while (c < 60 && o_busy) begin
      step();
      c++;
      if (c == ack_dly) i_free = ~i_free;
      chk({tag, ":onehot0"}, 32'($onehot0(o_gnt)), 32'(1));
      if (o_done !== '0) begin
        saw_done = 1'b1;
        done_c   = c;
        done_v   = o_done;
        chk({tag, ":gnt_held"}, 32'(o_gnt), 32'(eg));
      end
      if (o_timeout) begin
        saw_to = 1'b1;
        to_c   = c;
        chk({tag, ":gnt_cleared"}, 32'(o_gnt), 32'(0));
        chk({tag, ":busy_stall"}, 32'(o_busy), 32'(1));
      end
    end
    chk({tag, ":ended"}, 32'(o_busy), 32'(0));
    if (ack_dly + SS + 1 <= TO) begin
      chk({tag, ":done_seen"}, 32'(saw_done), 32'(1));
      chk({tag, ":done_lat"}, 32'(done_c), 32'(ack_dly + SS + 1));
      chk({tag, ":done_val"}, 32'(done_v), 32'(eg));
      chk({tag, ":no_timeout"}, 32'(saw_to), 32'(0));
    end else begin
      chk({tag, ":timeout_seen"}, 32'(saw_to), 32'(1));
      chk({tag, ":timeout_lat"}, 32'(to_c), 32'(TO));
      chk({tag, ":no_done"}, 32'(saw_done), 32'(0));
    end
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    logic d0;
    bit   got;
    int   base_tog, base_fin;

    rst = 1'b1; i_req = '0; i_free = 1'b0;
    step();
    chk("rst:gnt", 32'(o_gnt), 32'(0));
    chk("rst:done", 32'(o_done), 32'(0));
    chk("rst:drive", 32'(o_drive), 32'(0));
    chk("rst:busy", 32'(o_busy), 32'(0));
    chk("rst:timeout", 32'(o_timeout), 32'(0));
    step();
    rst = 1'b0;
    step();
    chk("idle:no_gnt", 32'(o_gnt), 32'(0));
    chk("idle:not_busy", 32'(o_busy), 32'(0));

    // single requester, ack 3 cycles after drive
    i_req = 4'b0001;
    txn(3, 1'b0, "t2_single");
    chk("t2:drive_hi", 32'(o_drive), 32'(1));
    i_req = 4'b0010;
    txn(0, 1'b0, "pre_t1");

    // reset in the middle of WAIT with o_drive high
    i_req = 4'b1111;
    d0 = o_drive; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (o_drive !== d0) got = 1'b1;
    end
    chk("t1:grant_seen", 32'(got), 32'(1));
    chk("t1:gnt", 32'(o_gnt), 32'(N'(1) << predict(i_req, m_ptr)));
    chk("t1:drive_hi", 32'(o_drive), 32'(1));
    step();
    #3 rst = 1'b1;
    #1;
    chk("t1:gnt", 32'(o_gnt), 32'(0));
    chk("t1:drive", 32'(o_drive), 32'(0));
    chk("t1:busy", 32'(o_busy), 32'(0));
    chk("t1:done", 32'(o_done), 32'(0));
    chk("t1:timeout", 32'(o_timeout), 32'(0));
    i_free = 1'b0;
    m_ptr  = 0;
    step();
    step();
    rst = 1'b0;

    // round robin with all requests held; first grant proves pointer returned to 0
    base_tog = tog_total;
    for (int t = 0; t < 5; t++) begin
      txn(2, 1'b0, "t3_rr");
      if (t == 3) chk("t3:toggles_by_4th_done", 32'(tog_total - base_tog), 32'(4));
    end

    // pointer wrap: grant bit 2, then 0101 wraps to bit 0 before bit 2
    i_req = 4'b0100;
    txn(1, 1'b0, "t4_b2");
    i_req = 4'b0101;
    txn(1, 1'b0, "t4_wrap");
    txn(1, 1'b0, "t4_b2_again");

    // timeout with late ack, first cycle past the race, and the exact race
    i_req = 4'b0010;
    txn(15, 1'b0, "t5_timeout");
    txn(TO - SS, 1'b0, "t5_just_late");
    txn(TO - SS - 1, 1'b0, "t6_race");

    // randomized traffic, occasionally dropping the request while granted
    base_tog = tog_total;
    base_fin = fin_total;
    for (int t = 0; t < 1000; t++) begin
      i_req = N'($urandom_range(1, 15));
      txn(int'($urandom_range(1, 20)), bit'($urandom_range(0, 3) == 0), "rand");
    end
    i_req = '0;
    step();
    step();
    chk("rand:toggles_eq_finished", 32'(tog_total - base_tog), 32'(fin_total - base_fin));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
